// File: rtl/frame_serializer.sv
// frame_serializer: accepts a ROWSxCOLS frame in parallel and streams it word by word in row-major order,
// with a one-frame pending buffer so back-to-back frames stream without bubbles.
module frame_serializer #(
  parameter int DW   = 11,
  parameter int ROWS = 2,
  parameter int COLS = 4,
  localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1,
  localparam int CW  = (COLS > 1) ? $clog2(COLS) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data [ROWS][COLS],
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic [RW-1:0] out_row,
  output logic [CW-1:0] out_col,
  output logic          out_last,
  output logic [7:0]    frame_cnt
);
  typedef enum logic {IDLE, SEND} state_t;
  localparam logic [RW-1:0] LAST_ROW = RW'(ROWS - 1);
  localparam logic [CW-1:0] LAST_COL = CW'(COLS - 1);
  state_t        state_q, state_d;
  logic [DW-1:0] act_q  [ROWS][COLS];
  logic [DW-1:0] act_d  [ROWS][COLS];
  logic [DW-1:0] pend_q [ROWS][COLS];
  logic [DW-1:0] pend_d [ROWS][COLS];
  logic          pend_full_q, pend_full_d;
  logic [RW-1:0] row_q, row_d;
  logic [CW-1:0] col_q, col_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          accept, beat, last_pos, fin, to_act;
  assign in_ready  = !pend_full_q;
  assign out_valid = state_q == SEND;
  assign last_pos  = (row_q == LAST_ROW) && (col_q == LAST_COL);
  assign out_last  = out_valid && last_pos;
  assign accept    = in_valid && in_ready;
  assign beat      = out_valid && out_ready;
  assign fin       = beat && last_pos;
  // A new frame goes straight to active when nothing is being sent or the current frame ends now
  assign to_act    = (state_q == IDLE) || (fin && !pend_full_q);
  assign out_data  = act_q[row_q][col_q];
  assign out_row   = row_q;
  assign out_col   = col_q;
  assign frame_cnt = cnt_q;
  always_comb begin
    state_d     = state_q;
    act_d       = act_q;
    pend_d      = pend_q;
    pend_full_d = pend_full_q;
    row_d       = row_q;
    col_d       = col_q;
    cnt_d       = cnt_q;
    if (accept && to_act) act_d = in_data;
    else if (accept) begin
      pend_d      = in_data;
      pend_full_d = 1'b1;
    end
    if (fin) begin
      cnt_d   = cnt_q + 8'd1;
      row_d   = '0;
      col_d   = '0;
      state_d = (pend_full_q || accept) ? SEND : IDLE;
      if (pend_full_q) begin
        act_d       = pend_q;
        pend_full_d = 1'b0;
      end
    end else if (beat) begin
      col_d = (col_q == LAST_COL) ? '0 : col_q + 1'b1;
      row_d = (col_q == LAST_COL) ? row_q + 1'b1 : row_q;
    end else if (accept && state_q == IDLE) state_d = SEND;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      act_q       <= '{default: '0};
      pend_q      <= '{default: '0};
      pend_full_q <= 1'b0;
      row_q       <= '0;
      col_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      act_q       <= act_d;
      pend_q      <= pend_d;
      pend_full_q <= pend_full_d;
      row_q       <= row_d;
      col_q       <= col_d;
      cnt_q       <= cnt_d;
    end
  end
endmodule

// File: doc/frame_serializer.md
# frame_serializer

Transmit-side counterpart to the array-capturing blocks driven by our Nicotb benches. It accepts a whole frame of ROWS×COLS words in parallel on a valid/ready handshake, then emits the words one per beat on a valid/ready stream in row-major order, with row/column tags and a last flag. A one-frame pending buffer lets back-to-back frames stream with no bubble beat between them.

## Interface
- DW, default 11: word width in bits.
- ROWS, default 2: rows per frame.
- COLS, default 4: columns per frame.
- NW, derived, ROWS*COLS: words per frame.
- clk  input  1  the only clock; all state changes on its rising edge.
- rst  input  1  reset, asynchronous and active-high.
- in_valid  input  1  a frame is present on in_data.
- in_ready  output  1  the block accepts a frame this cycle.
- in_data  input  DW×[ROWS][COLS]  frame, unpacked array; element [r][c] is one word.
- out_valid  output  1  out_data holds a valid word.
- out_ready  input  1  the sink accepts the word this cycle.
- out_data  output  DW  current word, equal to active[row][col].
- out_row  output  $clog2(ROWS) (min 1)  row index of out_data.
- out_col  output  $clog2(COLS) (min 1)  column index of out_data.
- out_last  output  1  high on the final word of the frame (row ROWS-1, col COLS-1).
- frame_cnt  output  8  completed frames; wraps 255→0.

## Operation
- Storage: active buffer (frame being sent) plus pending buffer (next frame), each with a full flag; beat index idx, 0..NW-1.
- States: IDLE (active empty), SEND (active full).
- in_ready = !pending_full; combinational from state only, never from in_valid.
- Accept = in_valid && in_ready; out beat = out_valid && out_ready.
- Frame entry on accept: it loads into active if active is empty, or if active is full and finishing (beat with out_last) this cycle while pending is empty; otherwise it loads into pending.
- IDLE→SEND on accept; idx=0.
- SEND beat with out_last=0: idx+1. out_row = idx / COLS, out_col = idx % COLS.
- SEND beat with out_last=1: frame_cnt+1; idx→0; if pending full, move pending→active and clear pending_full (state stays SEND); else if accept, as above (stays SEND); else →IDLE.
- out_valid = active_full. out_data/out_row/out_col/out_last stable while out_valid && !out_ready.
- in_data is sampled only on accept; changes at other times have no effect.
- ROWS=1 or COLS=1 legal; NW=1 means every beat has out_last=1.

## Timing
- Reset (asynchronous assert, synchronous release at next edge): out_valid=0, in_ready=1, out_data=0, out_row=0, out_col=0, out_last=0 (NW>1), frame_cnt=0, both buffers cleared, state IDLE.
- Latency: a frame accepted at edge N drives its word [0][0] with out_valid=1 after edge N when active was empty.
- Throughput: with out_ready held high, NW beats per frame, and the next frame's [0][0] immediately follows the prior last beat (no gap) when it was pending or accepted on the last-beat cycle.
- Capacity: two frames in flight; in_ready falls after edge where pending fills, rises after the edge pending moves to active.
- rst mid-frame: partial frame and pending frame discarded, no residual out_valid; frame_cnt returns to 0.
- out_ready may toggle arbitrarily; no word is skipped or repeated.

## Test plan
- Reset values: assert rst 3 cycles with in_valid=1 -> out_valid=0, in_ready=1, frame_cnt=0, nothing accepted; after release, accept works.
- Single frame: in_data[r][c]=16*r+c, out_ready=1 -> 8 beats 0x000,0x001,0x002,0x003,0x010..0x013, tags (0,0)..(1,3), out_last only on 8th, first beat one cycle after accept, frame_cnt=1.
- Back-to-back: 3 frames offered continuously, out_ready=1 -> 24 consecutive out_valid beats with no gap, in_ready low while pending full, frame_cnt=3.
- Backpressure: random 50% out_ready over 10 frames -> output sequence equals input words in row-major order, data stable during stall, in_ready=0 whenever two frames held.
- Mid-frame reset: assert rst after 3rd beat with pending full -> out_valid=0 at once, frame_cnt=0, next frame starts at (0,0) with its own data.
- Wrap: 256 frames -> frame_cnt reads 0 after the 256th last beat.
